// File: rtl/clint_pkg.sv
// clint_pkg: shared constants, types and helpers for the core-local interruptor.
//   CLINT_*          : byte offsets of the register regions
//   MAX_HARTS        : upper bound on harts served by one instance
//   clint_sel_e      : register-port decode result
//   strb_merge()     : byte-enable merge of a 64-bit write into an existing word
package clint_pkg;

   localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
   localparam logic [15:0] CLINT_MTIME         = 16'hBFF8;

   localparam int MAX_HARTS = 16;

   typedef enum logic [1:0] {
      SEL_NONE     = 2'd0,
      SEL_MSIP     = 2'd1,
      SEL_MTIMECMP = 2'd2,
      SEL_MTIME    = 2'd3
   } clint_sel_e;

   function automatic logic [63:0] strb_merge(input logic [63:0] old_word,
                                              input logic [63:0] new_word,
                                              input logic [7:0]  strb);
      logic [63:0] res;
      res = old_word;
      for (int i = 0; i < 8; i++) begin
         if (strb[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/clint_timebase.sv
// clint_timebase: 64-bit mtime counter with tick prescaler and debug stop.
//   clk, rst      : clock, synchronous active-low reset
//   stop          : freeze prescaler and mtime
//   wr_en/wr_data : register-port write of mtime (overrides a same-cycle tick)
//   mtime         : current timer value
//   tick          : high in the cycle whose clock edge advances mtime
module clint_timebase #(
   parameter int TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stop,
   input  logic        wr_en,
   input  logic [63:0] wr_data,
   output logic [63:0] mtime,
   output logic        tick
);

   localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc;

   assign tick = !stop && (presc == PRESC_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc <= '0;
         mtime <= '0;
      end else begin
         // Prescaler keeps running through mtime writes; only stop holds it.
         if (!stop) presc <= tick ? '0 : presc + 1'b1;
         if (wr_en)     mtime <= wr_data;
         else if (tick) mtime <= mtime + 64'd1;
      end
   end

endmodule

// File: rtl/clint_mh.sv
// clint_mh: multi-hart core-local interruptor.
//   clk, rst                : clock, synchronous active-low reset
//   req_*                   : single-outstanding register request (valid/ready)
//   resp_*                  : registered response (rdata, err for unmapped offset)
//   mtime_stop              : debug freeze of the timebase
//   mtip[h], msip[h]        : raw timer / software pending bits per hart
// Map: msip[h] at 0x0000+4h (two harts per 64-bit word), mtimecmp[h] at
// 0x4000+8h, mtime at 0xBFF8. Address bits 2:0 are ignored.
module clint_mh
   import clint_pkg::*;
#(
   parameter int NUM_HARTS = 1,
   parameter int TICK_DIV  = 1,
   parameter int ADDR_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [63:0]          req_wdata,
   input  logic [7:0]           req_wstrb,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [63:0]          resp_rdata,
   output logic                 resp_err,
   input  logic                 mtime_stop,
   output logic [NUM_HARTS-1:0] mtip,
   output logic [NUM_HARTS-1:0] msip
);

   localparam int                NUM_PAIRS   = (NUM_HARTS + 1) / 2;
   localparam logic [ADDR_W-1:0] MSIP_BASE_A = ADDR_W'(CLINT_MSIP_BASE);
   localparam logic [ADDR_W-1:0] MSIP_SPAN   = ADDR_W'(8 * NUM_PAIRS);
   localparam logic [ADDR_W-1:0] CMP_BASE_A  = ADDR_W'(CLINT_MTIMECMP_BASE);
   localparam logic [ADDR_W-1:0] CMP_SPAN    = ADDR_W'(8 * NUM_HARTS);
   localparam logic [ADDR_W-1:0] MTIME_A     = ADDR_W'(CLINT_MTIME);
   localparam logic [ADDR_W-1:0] WORD_MASK   = ~ADDR_W'(7);

   logic                 accept;
   logic                 wr_acc;
   logic [ADDR_W-1:0]    word_addr;
   logic [ADDR_W-1:0]    msip_off;
   logic [ADDR_W-1:0]    cmp_off;
   logic [2:0]           pair_idx;
   logic [3:0]           hart_idx;
   clint_sel_e           sel;

   logic [63:0]          mtimecmp [NUM_HARTS];
   logic [NUM_HARTS-1:0] msip_q;
   logic [NUM_HARTS-1:0] mtip_q;
   logic [MAX_HARTS-1:0] msip_pad;

   logic [63:0]          mtime;
   logic                 tick;
   logic                 mtime_wr;
   logic                 upd_q;

   logic [63:0]          msip_word;
   logic [63:0]          cmp_rd;
   logic [63:0]          rd_word;
   logic [63:0]          wr_word;

   assign req_ready = !resp_valid || resp_ready;
   assign accept    = req_valid && req_ready;
   assign wr_acc    = accept && req_we;

   assign word_addr = req_addr & WORD_MASK;
   // Offsets below a region base wrap to large values, so one unsigned
   // compare against the span covers both ends of the region.
   assign msip_off  = word_addr - MSIP_BASE_A;
   assign cmp_off   = word_addr - CMP_BASE_A;
   assign pair_idx  = 3'(msip_off >> 3);
   assign hart_idx  = 4'(cmp_off >> 3);

   always_comb begin
      sel = SEL_NONE;
      if (word_addr == MTIME_A)     sel = SEL_MTIME;
      else if (cmp_off < CMP_SPAN)  sel = SEL_MTIMECMP;
      else if (msip_off < MSIP_SPAN) sel = SEL_MSIP;
   end

   // Absent odd hart of the last msip pair reads as 0 through the padding.
   assign msip_pad  = MAX_HARTS'(msip_q);
   assign msip_word = {31'd0, msip_pad[{pair_idx, 1'b1}], 31'd0, msip_pad[{pair_idx, 1'b0}]};

   always_comb begin
      cmp_rd = '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
         if (hart_idx == 4'(h)) cmp_rd = mtimecmp[h];
      end
   end

   always_comb begin
      rd_word = '0;
      case (sel)
         SEL_MSIP:     rd_word = msip_word;
         SEL_MTIMECMP: rd_word = cmp_rd;
         SEL_MTIME:    rd_word = mtime;
         default:      rd_word = '0;
      endcase
   end

   assign wr_word  = strb_merge(rd_word, req_wdata, req_wstrb);
   assign mtime_wr = wr_acc && (sel == SEL_MTIME);

   clint_timebase #(
      .TICK_DIV (TICK_DIV)
   ) u_timebase (
      .clk     (clk),
      .rst     (rst),
      .stop    (mtime_stop),
      .wr_en   (mtime_wr),
      .wr_data (wr_word),
      .mtime   (mtime),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
         msip_q <= '0;
      end else if (wr_acc) begin
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (sel == SEL_MTIMECMP && hart_idx == 4'(h)) mtimecmp[h] <= wr_word;
            if (sel == SEL_MSIP && pair_idx == 3'(h / 2)) begin
               msip_q[h] <= (h % 2 == 1) ? wr_word[32] : wr_word[0];
            end
         end
      end
   end

   // The compare result can only change after mtime or an mtimecmp changed,
   // so the compare register is refreshed one cycle after such a change and
   // otherwise holds. Net latency from a write or tick is two cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         upd_q  <= 1'b0;
         mtip_q <= '0;
      end else begin
         upd_q <= tick || (wr_acc && (sel == SEL_MTIME || sel == SEL_MTIMECMP));
         if (upd_q) begin
            for (int h = 0; h < NUM_HARTS; h++) mtip_q[h] <= (mtime >= mtimecmp[h]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else if (accept) begin
         resp_valid <= 1'b1;
         resp_rdata <= req_we ? 64'd0 : rd_word;
         resp_err   <= (sel == SEL_NONE);
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

   assign mtip = mtip_q;
   assign msip = msip_q;

endmodule
